// File: rtl/sad_search_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vbsme_pkg
// Purpose : Shared types and constants for the SAD full-search sequencer.
//           - state_t       : sequencer FSM encoding (S_IDLE/S_RUN/S_DRAIN/S_DONE)
//           - SAD_MAX       : all-ones SAD; slice to the SAD width in use
//           - num_positions : number of candidate block positions in a frame
// Revision: 1.0 - initial release
// ============================================================================
package vbsme_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int SAD_MAX_W = 64;
  localparam logic [SAD_MAX_W-1:0] SAD_MAX = {SAD_MAX_W{1'b1}};

  // Candidate positions: cols 0..fw-blk and rows 0..fh-blk.
  function automatic int num_positions(input int fw, input int fh, input int blk);
    return (fw - blk + 1) * (fh - blk + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sad_search_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : sad_search_sequencer_if
// Purpose : Control, issue and result bundle of the SAD search sequencer.
//   Start       host -> seq   begin a search (sampled only while idle)
//   IssueReady  pipe -> seq   pipeline accepts an index this cycle
//   IssueValid  seq  -> pipe  IssueIndex valid
//   IssueIndex  seq  -> pipe  candidate index = row*FRAME_W + col
//   ResultValid pipe -> seq   one in-order SAD result returns
//   ResultSAD   pipe -> seq   SAD of the oldest outstanding index
//   Busy/Done/BestSAD/BestIndex/EvalCount/ProtoErr  seq -> host status
// Modports: master (host/pipeline side), slave (sequencer side).
// Revision: 1.0 - initial release
// ============================================================================
interface sad_search_sequencer_if #(
  parameter int IDX_W = 32,
  parameter int SAD_W = 32
);
  logic             Start;
  logic             IssueReady;
  logic             IssueValid;
  logic [IDX_W-1:0] IssueIndex;
  logic             ResultValid;
  logic [SAD_W-1:0] ResultSAD;
  logic             Busy;
  logic             Done;
  logic [SAD_W-1:0] BestSAD;
  logic [IDX_W-1:0] BestIndex;
  logic [IDX_W-1:0] EvalCount;
  logic             ProtoErr;

  modport master (
    output Start, IssueReady, ResultValid, ResultSAD,
    input  IssueValid, IssueIndex, Busy, Done, BestSAD, BestIndex, EvalCount, ProtoErr
  );

  modport slave (
    input  Start, IssueReady, ResultValid, ResultSAD,
    output IssueValid, IssueIndex, Busy, Done, BestSAD, BestIndex, EvalCount, ProtoErr
  );
endinterface
`default_nettype wire

// File: rtl/sad_search_sequencer_index_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sad_index_fifo
// Purpose : Small FIFO of issued candidate indices so each returning SAD can
//           be paired with the index that produced it. Push and pop may occur
//           in the same cycle (including when full, as the pop frees a slot).
// Ports   : Clk, Reset (async, active-high)
//           push_i/push_data_i : store an issued index
//           pop_i              : retire the oldest entry
//           head_o             : oldest entry;  count_o : entries held
// Revision: 1.0 - initial release
// ============================================================================
module sad_index_fifo
  import vbsme_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = 3
) (
  input  wire logic             Clk,
  input  wire logic             Reset,
  input  wire logic             push_i,
  input  wire logic [WIDTH-1:0] push_data_i,
  input  wire logic             pop_i,
  output logic      [WIDTH-1:0] head_o,
  output logic      [CNT_W-1:0] count_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= ptr_inc(wr_q);
      if (pop_i)  rd_q <= ptr_inc(rd_q);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge Clk) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/sad_search_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : sad_search_sequencer
// Purpose : Sequences a full-search motion-estimation pass: issues every
//           candidate index to the SAD pipeline, consumes the in-order SAD
//           results, tracks the minimum SAD and its index, and signals Done.
// Ports   : Clk   - clock, rising edge
//           Reset - asynchronous, active-high
//           bus   - sad_search_sequencer_if.slave (start/issue/result/status)
// Config  : EARLY_EXIT_EN - when defined, an accepted zero SAD stops further
//           issues and the search drains and completes early.
// Revision: 1.0 - initial release
// ============================================================================
module sad_search_sequencer
  import vbsme_pkg::*;
#(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int BLK     = 4,
  parameter int SAD_W   = 32,
  parameter int IDX_W   = 32,
  parameter int MAX_OUT = 4
) (
  input wire logic              Clk,
  input wire logic              Reset,
  sad_search_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int NPOS  = num_positions(FRAME_W, FRAME_H, BLK);
  localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(FRAME_W - BLK);
  localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(FRAME_H - BLK);
  localparam logic [IDX_W-1:0] STRIDE   = IDX_W'(FRAME_W);
  localparam logic [SAD_W-1:0] SAD_INIT = SAD_MAX[SAD_W-1:0];

  if ($clog2(NPOS) > IDX_W) begin : g_idx_w_check
    $error("IDX_W too narrow for the number of candidate positions");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] eval_q, eval_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic             proto_q, proto_d;

  logic [CNT_W-1:0] outstanding;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] cur_idx;
  logic             have_out;
  logic             accept;
  logic             early_hit;
  logic             issue_valid;
  logic             issue;
  logic             last_pos;

  assign cur_idx  = row_q * STRIDE + col_q;
  assign have_out = (outstanding != '0);
  assign accept   = bus.ResultValid && have_out;
  assign last_pos = (col_q == COL_LAST) && (row_q == ROW_LAST);

`ifdef EARLY_EXIT_EN
  assign early_hit = accept && (bus.ResultSAD == '0);
`else
  assign early_hit = 1'b0;
`endif

  // A result returning this cycle frees a slot, so a full window may still
  // issue. A zero-SAD hit blocks the issue in the very cycle it is seen.
  assign issue_valid = (state_q == S_RUN) && !early_hit &&
                       ((outstanding < CNT_W'(MAX_OUT)) || bus.ResultValid);
  assign issue       = issue_valid && bus.IssueReady;

  sad_index_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (IDX_W),
    .CNT_W (CNT_W)
  ) u_index_fifo (
    .Clk         (Clk),
    .Reset       (Reset),
    .push_i      (issue),
    .push_data_i (cur_idx),
    .pop_i       (accept),
    .head_o      (head_idx),
    .count_o     (outstanding)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      eval_q     <= '0;
      best_idx_q <= '0;
      best_sad_q <= SAD_INIT;
      proto_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      eval_q     <= eval_d;
      best_idx_q <= best_idx_d;
      best_sad_q <= best_sad_d;
      proto_q    <= proto_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    eval_d     = eval_q;
    best_idx_d = best_idx_q;
    best_sad_d = best_sad_q;
    proto_d    = proto_q;

    // Strict less-than: on a tie the earlier (already stored) index wins.
    if (accept) begin
      eval_d = eval_q + 1'b1;
      if (bus.ResultSAD < best_sad_q) begin
        best_sad_d = bus.ResultSAD;
        best_idx_d = head_idx;
      end
    end
    if (bus.ResultValid && !have_out) proto_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          state_d    = S_RUN;
          col_d      = '0;
          row_d      = '0;
          eval_d     = '0;
          best_idx_d = '0;
          best_sad_d = SAD_INIT;
        end
      end
      S_RUN: begin
        // The last position does not advance, so IssueIndex stays in range.
        if (issue) begin
          if (last_pos) begin
            state_d = S_DRAIN;
          end else if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        if (early_hit) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!have_out || (outstanding == CNT_W'(1) && accept)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.IssueValid = issue_valid;
  assign bus.IssueIndex = cur_idx;
  assign bus.Busy       = (state_q != S_IDLE);
  assign bus.Done       = (state_q == S_DONE);
  assign bus.BestSAD    = best_sad_q;
  assign bus.BestIndex  = best_idx_q;
  assign bus.EvalCount  = eval_q;
  assign bus.ProtoErr   = proto_q;

endmodule
`default_nettype wire

// File: tb/tb_sad_search_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_sad_search_sequencer
// Purpose : Directed self-checking bench for sad_search_sequencer on an 8x8
//           frame with 4x4 blocks (25 candidates) and a 2-deep result window.
//           A cycle-stepped pipeline echo returns SAD results in order after a
//           fixed delay. EARLY_EXIT_EN enables the early-exit scenario.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sad_search_sequencer;
  localparam int FW      = 8;
  localparam int FH      = 8;
  localparam int BK      = 4;
  localparam int SW      = 32;
  localparam int IW      = 32;
  localparam int MO      = 2;
  localparam int NPOS    = (FW - BK + 1) * (FH - BK + 1);
  localparam int MAX_CYC = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sad_search_sequencer_if #(.IDX_W(IW), .SAD_W(SW)) bus();

  sad_search_sequencer #(
    .FRAME_W (FW), .FRAME_H (FH), .BLK (BK),
    .SAD_W (SW), .IDX_W (IW), .MAX_OUT (MO)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {int idx; int due;} pend_t;
  pend_t pend[$];
  int    issued[$];

  int checks = 0;
  int fails  = 0;

  // Per-run observations
  int done_cnt, hold_viol, cap_viol, valid_viol, drops, proto_low;
  int post_hit, hit_seen, timed_out;

  function automatic logic [SW-1:0] sad_of(input int mode, input int idx);
    case (mode)
      0:       return SW'(idx + 5);
      1:       return (idx == 20 || idx == 28) ? SW'(7) : SW'(100);
      default: return (idx == 10) ? SW'(0) : SW'(50);
    endcase
  endfunction

  function automatic int exp_idx(input int k);
    return (k / 5) * FW + (k % 5);
  endfunction

  // Starts a search and steps it cycle by cycle until Done, a stop count of
  // issues (stop_after > 0), or the cycle budget.
  task automatic run_search(input int mode, input int delay, input bit toggle_ready,
                            input int stop_after);
    int    cyc;
    int    out_before;
    bit    rv;
    bit    finished;
    bit    prev_stall;
    int    prev_idx;
    pend_t e;
    issued.delete(); pend.delete();
    done_cnt = 0; hold_viol = 0; cap_viol = 0; valid_viol = 0; drops = 0;
    proto_low = 0; post_hit = 0; hit_seen = 0; timed_out = 0;
    cyc = 0; finished = 0; prev_stall = 0; prev_idx = 0;
    while (!finished) begin
      @(negedge clk);
      bus.Start      = (cyc == 0);
      bus.IssueReady = toggle_ready ? (cyc % 2 == 0) : 1'b1;
      rv = 0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        rv = 1;
        e = pend.pop_front();
        bus.ResultSAD = sad_of(mode, e.idx);
        if (bus.ResultSAD == '0) hit_seen = 1;
      end
      bus.ResultValid = rv;
      out_before = pend.size() + (rv ? 1 : 0);
      #1;
      if (bus.IssueValid && out_before >= MO && !rv) cap_viol++;
      if (bus.Busy && issued.size() < NPOS && out_before >= MO && !rv) drops++;
      if (bus.Busy && issued.size() < NPOS && out_before < MO && hit_seen == 0 &&
          !bus.IssueValid) valid_viol++;
      if (prev_stall && int'(bus.IssueIndex) != prev_idx) hold_viol++;
      prev_stall = bus.IssueValid && !bus.IssueReady;
      prev_idx   = int'(bus.IssueIndex);
      if (!bus.ProtoErr) proto_low++;
      if (bus.IssueValid && bus.IssueReady) begin
        issued.push_back(int'(bus.IssueIndex));
        pend.push_back('{idx: int'(bus.IssueIndex), due: cyc + delay});
        if (hit_seen != 0) post_hit++;
      end
      if (bus.Done) begin
        done_cnt++;
        finished = 1;
      end
      if (stop_after > 0 && issued.size() >= stop_after) finished = 1;
      cyc++;
      if (!finished && cyc > MAX_CYC) begin
        timed_out = 1;
        finished  = 1;
        checks++; fails++;
        $display("FAIL run_timeout: got %0d cycles without Done, required < %0d", cyc, MAX_CYC);
      end
    end
  endtask

  // Returns to idle inputs and checks Done was a single-cycle pulse.
  task automatic finish_run(input string name);
    @(negedge clk);
    bus.Start = 0; bus.ResultValid = 0; bus.IssueReady = 1;
    #1;
    checks++;
    if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_after_done: got Done=%0b Busy=%0b required 0/0", name, bus.Done, bus.Busy);
    end
  endtask

  task automatic check_seq(input string name);
    int err = 0;
    for (int k = 0; k < issued.size() && k < NPOS; k++)
      if (issued[k] != exp_idx(k)) err++;
    checks++;
    if (issued.size() != NPOS || err != 0) begin
      fails++;
      $display("FAIL %s_issue_seq: got %0d issues (%0d wrong) required %0d in order",
               name, issued.size(), err, NPOS);
    end
  endtask

  task automatic check_result(input string name, input int b_sad, input int b_idx, input int ev);
    checks++;
    if (bus.BestSAD !== SW'(b_sad)) begin
      fails++; $display("FAIL %s_best_sad: got %0d required %0d", name, bus.BestSAD, b_sad);
    end
    checks++;
    if (bus.BestIndex !== IW'(b_idx)) begin
      fails++; $display("FAIL %s_best_idx: got %0d required %0d", name, bus.BestIndex, b_idx);
    end
    checks++;
    if (bus.EvalCount !== IW'(ev)) begin
      fails++; $display("FAIL %s_eval_count: got %0d required %0d", name, bus.EvalCount, ev);
    end
    checks++;
    if (done_cnt != 1) begin
      fails++; $display("FAIL %s_done_count: got %0d required 1", name, done_cnt);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (bus.IssueValid !== 1'b0 || bus.IssueIndex !== '0 || bus.Busy !== 1'b0 ||
        bus.Done !== 1'b0) begin
      fails++;
      $display("FAIL %s_ctrl: got IV=%0b II=%0d Busy=%0b Done=%0b required 0/0/0/0",
               name, bus.IssueValid, bus.IssueIndex, bus.Busy, bus.Done);
    end
    checks++;
    if (bus.BestSAD !== {SW{1'b1}} || bus.BestIndex !== '0 || bus.EvalCount !== '0 ||
        bus.ProtoErr !== 1'b0) begin
      fails++;
      $display("FAIL %s_status: got BestSAD=%0h BestIndex=%0d Eval=%0d ProtoErr=%0b required ffffffff/0/0/0",
               name, bus.BestSAD, bus.BestIndex, bus.EvalCount, bus.ProtoErr);
    end
  endtask

  task automatic test_reset();
    bus.Start = 0; bus.IssueReady = 1; bus.ResultValid = 0; bus.ResultSAD = '0;
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    check_reset_values("reset_held");
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    #1;
    check_reset_values("reset_released");
  endtask

  task automatic test_full_search();
    run_search(0, 3, 1'b0, 0);
    check_seq("t1");
    check_result("t1", 5, 0, NPOS);
    checks++;
    if (cap_viol != 0) begin
      fails++; $display("FAIL t1_window_cap: got %0d overfull issues required 0", cap_viol);
    end
    finish_run("t1");
  endtask

  task automatic test_tie_keeps_earliest();
    run_search(1, 3, 1'b0, 0);
    check_seq("t2");
    check_result("t2", 7, 20, NPOS);
    finish_run("t2");
  endtask

  task automatic test_backpressure();
    run_search(0, 6, 1'b1, 0);
    check_seq("t3");
    check_result("t3", 5, 0, NPOS);
    checks++;
    if (cap_viol != 0 || valid_viol != 0) begin
      fails++;
      $display("FAIL t3_issue_valid: got %0d overfull and %0d missing IssueValid cycles required 0/0",
               cap_viol, valid_viol);
    end
    checks++;
    if (drops == 0) begin
      fails++; $display("FAIL t3_window_full_seen: got %0d full-window cycles required > 0", drops);
    end
    checks++;
    if (hold_viol != 0) begin
      fails++; $display("FAIL t3_index_hold: got %0d index changes under stall required 0", hold_viol);
    end
    finish_run("t3");
  endtask

  task automatic test_reset_mid_search();
    int done_in_reset = 0;
    run_search(0, 3, 1'b0, 10);
    @(posedge clk);
    #2;
    rst = 1;
    bus.ResultValid = 0; bus.Start = 0;
    #1;
    check_reset_values("t4_mid_reset");
    repeat (2) begin
      @(negedge clk);
      #1;
      if (bus.Done) done_in_reset++;
    end
    checks++;
    if (done_in_reset != 0) begin
      fails++; $display("FAIL t4_no_done: got %0d Done cycles in reset required 0", done_in_reset);
    end
    @(negedge clk);
    rst = 0;
    pend.delete();
    run_search(0, 3, 1'b0, 0);
    checks++;
    if (issued.size() == 0 || issued[0] != 0) begin
      fails++;
      $display("FAIL t4_restart_idx: got first index %0d required 0",
               (issued.size() == 0) ? -1 : issued[0]);
    end
    check_result("t4", 5, 0, NPOS);
    finish_run("t4");
  endtask

  task automatic test_proto_err();
    @(negedge clk);
    bus.ResultValid = 1; bus.ResultSAD = '0;
    @(negedge clk);
    bus.ResultValid = 0;
    #1;
    checks++;
    if (bus.ProtoErr !== 1'b1) begin
      fails++; $display("FAIL t5_proto_set: got %0b required 1", bus.ProtoErr);
    end
    checks++;
    if (bus.BestSAD !== SW'(5) || bus.BestIndex !== '0 || bus.EvalCount !== IW'(NPOS)) begin
      fails++;
      $display("FAIL t5_best_hold: got BestSAD=%0d BestIndex=%0d Eval=%0d required 5/0/%0d",
               bus.BestSAD, bus.BestIndex, bus.EvalCount, NPOS);
    end
    run_search(1, 3, 1'b0, 0);
    checks++;
    if (proto_low != 0 || bus.ProtoErr !== 1'b1) begin
      fails++;
      $display("FAIL t5_proto_sticky: got %0d cycles low, final %0b required 0 cycles, 1",
               proto_low, bus.ProtoErr);
    end
    check_result("t5", 7, 20, NPOS);
    finish_run("t5");
  endtask

`ifdef EARLY_EXIT_EN
  task automatic test_early_exit();
    run_search(2, 3, 1'b0, 0);
    check_result("t6", 0, 10, issued.size());
    checks++;
    if (hit_seen == 0 || post_hit != 0) begin
      fails++;
      $display("FAIL t6_stop_issue: got hit=%0d issues_after_hit=%0d required 1/0", hit_seen, post_hit);
    end
    checks++;
    if (issued.size() < 8 || issued.size() > 8 + MO) begin
      fails++;
      $display("FAIL t6_issue_count: got %0d issued required 8..%0d", issued.size(), 8 + MO);
    end
    finish_run("t6");
  endtask
`endif

  initial begin
    test_reset();
    test_full_search();
    test_tie_keeps_earliest();
    test_backpressure();
    test_reset_mid_search();
    test_proto_err();
`ifdef EARLY_EXIT_EN
    test_early_exit();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
